// File: rtl/xmem_arb.sv
// xmem_arb: round-robin two-requester data memory arbiter with burst lock and tagged read return
module xmem_arb #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {LK_NONE, LK_M0, LK_M1} lock_t;
  lock_t lock_owner, lock_next, gnt_own;
  logic last_gnt, last_next, rd_pend0, rd_pend1;
  logic lk0, lk1, over, released, gnt_lock;
  logic [CW-1:0] burst_cnt, burst_next;
  always_comb begin
    lk0 = lock_owner == LK_M0 && m0_req;
    lk1 = lock_owner == LK_M1 && m1_req;
    over = burst_cnt >= CW'(MAX_BURST);
    m0_gnt = lk0 ? (!over || !m1_req) : lk1 ? (over && m0_req) : m0_req && (!m1_req || last_gnt);
    m1_gnt = lk1 ? (!over || !m0_req) : lk0 ? (over && m1_req) : m1_req && (!m0_req || !last_gnt);
    mem_sel = m0_gnt | m1_gnt;
    mem_we = m0_gnt ? m0_we : m1_gnt & m1_we;
    mem_addr = m0_gnt ? m0_addr : m1_gnt ? m1_addr : '0;
    mem_wdata = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : '0;
    gnt_own = m1_gnt ? LK_M1 : LK_M0;
    gnt_lock = m0_gnt ? m0_lock : m1_lock;
    released = (lock_owner == LK_M0 && !m0_req) || (lock_owner == LK_M1 && !m1_req);
    last_next = mem_sel ? m1_gnt : last_gnt;
    lock_next = mem_sel ? (gnt_lock ? gnt_own : LK_NONE) : (released ? LK_NONE : lock_owner);
    burst_next = mem_sel ? (gnt_lock ? (lock_owner == gnt_own ? (over ? burst_cnt : burst_cnt + CW'(1)) : CW'(1)) : '0)
                         : (released ? '0 : burst_cnt);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
      lock_owner <= LK_NONE;
      burst_cnt <= '0;
      rd_pend0 <= 1'b0;
      rd_pend1 <= 1'b0;
    end else begin
      last_gnt <= last_next;
      lock_owner <= lock_next;
      burst_cnt <= burst_next;
      rd_pend0 <= m0_gnt & ~m0_we;
      rd_pend1 <= m1_gnt & ~m1_we;
    end
  end
  assign m0_rvalid = rd_pend0;
  assign m1_rvalid = rd_pend1;
  assign rdata = mem_rdata;
endmodule

// File: tb/tb_xmem_arb.sv
// tb_xmem_arb: directed scenarios plus randomized traffic against a behavioural arbiter model
module tb_xmem_arb;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr, mem_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, mem_wdata, rdata;
  logic [DW-1:0] mem_rdata = '0;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_sel, mem_we;
  logic [5:0] st;
  logic [DW-1:0] mem_arr [0:1023] = '{default: '0};
  int n_checks = 0;
  int n_fail = 0;
  int m_last, m_owner, m_burst;
  bit m_pend0, m_pend1;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] mdl_mem [0:1023] = '{default: '0};

  xmem_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign st = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_sel, mem_we};

  always @(posedge clk)
    if (mem_sel) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else mem_rdata <= mem_arr[mem_addr];
    end

  function automatic int model_gnt();
    bit r[2];
    r[0] = m0_req;
    r[1] = m1_req;
    if (m_owner >= 0 && r[m_owner])
      return (m_burst < MB || !r[1-m_owner]) ? m_owner : 1 - m_owner;
    if (r[0] && r[1]) return 1 - m_last;
    if (r[0]) return 0;
    if (r[1]) return 1;
    return -1;
  endfunction

  task automatic model_tick(input int g);
    bit r[2], lk[2];
    r[0] = m0_req; r[1] = m1_req; lk[0] = m0_lock; lk[1] = m1_lock;
    if (g == 0) begin if (m0_we) mdl_mem[m0_addr] = m0_wdata; else m_rd = mdl_mem[m0_addr]; end
    if (g == 1) begin if (m1_we) mdl_mem[m1_addr] = m1_wdata; else m_rd = mdl_mem[m1_addr]; end
    if (rst) begin
      m_last = 1; m_owner = -1; m_burst = 0; m_pend0 = 0; m_pend1 = 0;
      return;
    end
    m_pend0 = (g == 0) && !m0_we;
    m_pend1 = (g == 1) && !m1_we;
    if (m_owner >= 0 && !r[m_owner]) begin m_owner = -1; m_burst = 0; end
    if (g >= 0) begin
      m_last = g;
      if (lk[g]) begin
        m_burst = (m_owner == g) ? ((m_burst + 1 > MB) ? MB : m_burst + 1) : 1;
        m_owner = g;
      end else begin
        m_owner = -1; m_burst = 0;
      end
    end
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; idle(); tick(); rst = 0;
    m_last = 1; m_owner = -1; m_burst = 0; m_pend0 = 0; m_pend1 = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (st !== 6'b00_00_00) begin n_fail++; $display("FAIL reset_status got %b exp 000000", st); end
    n_checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++; $display("FAIL reset_mem_bus got addr %h wdata %h exp 0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_conflict();
    logic [5:0] exp_st [3] = '{6'b10_00_10, 6'b01_10_10, 6'b00_01_00};
    logic [AW-1:0] exp_a [3] = '{10'd5, 10'd6, 10'd0};
    do_reset();
    m0_req = 1; m0_addr = 10'd5; m1_req = 1; m1_addr = 10'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (st !== exp_st[i]) begin n_fail++; $display("FAIL conflict_st%0d got %b exp %b", i, st, exp_st[i]); end
      n_checks++;
      if (mem_addr !== exp_a[i]) begin n_fail++; $display("FAIL conflict_addr%0d got %0d exp %0d", i, mem_addr, exp_a[i]); end
      tick();
      if (i == 0) m0_req = 0;
      if (i == 1) m1_req = 0;
    end
  endtask

  task automatic test_write_read();
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 10'd3; m1_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if (st !== 6'b01_00_11 || mem_addr !== 10'd3 || mem_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write st %b addr %0d wdata %h exp 010011 3 deadbeef", st, mem_addr, mem_wdata);
    end
    tick();
    idle(); m0_req = 1; m0_addr = 10'd3;
    @(negedge clk);
    n_checks++;
    if (st !== 6'b10_00_10) begin n_fail++; $display("FAIL read_gnt got %b exp 100010", st); end
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (st !== 6'b00_10_00 || rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL read_data st %b rdata %h exp 001000 deadbeef", st, rdata);
    end
  endtask

  task automatic test_lock_burst();
    logic [5:0] exp_st [6] = '{6'b01_00_10, 6'b01_01_10, 6'b01_01_10, 6'b01_01_10, 6'b10_01_10, 6'b01_10_10};
    do_reset();
    m1_req = 1; m1_lock = 1; m1_addr = 10'd9;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (st !== exp_st[i]) begin n_fail++; $display("FAIL burst_c%0d got %b exp %b", i, st, exp_st[i]); end
      tick();
      if (i == 0) begin m0_req = 1; m0_addr = 10'd7; end
      if (i == 4) m0_req = 0;
    end
  endtask

  task automatic test_alternate();
    logic [5:0] e;
    do_reset();
    m0_req = 1; m1_req = 1;
    for (int i = 0; i < 6; i++) begin
      m0_addr = AW'(20 + i); m1_addr = AW'(40 + i);
      e = {(i % 2 == 0) ? 2'b10 : 2'b01, (i == 0) ? 2'b00 : (i % 2 == 0) ? 2'b01 : 2'b10, 2'b10};
      @(negedge clk);
      n_checks++;
      if (st !== e) begin n_fail++; $display("FAIL alternate_c%0d got %b exp %b", i, st, e); end
      tick();
    end
  endtask

  task automatic test_lock_release();
    do_reset();
    m0_req = 1; m0_lock = 1;
    @(negedge clk);
    tick();
    m0_req = 0; m0_lock = 0; m1_req = 1;
    @(negedge clk);
    n_checks++;
    if (st !== 6'b01_10_10) begin n_fail++; $display("FAIL release_same_cycle got %b exp 011010", st); end
    tick();
    m0_req = 1;
    @(negedge clk);
    n_checks++;
    if (st !== 6'b10_01_10) begin n_fail++; $display("FAIL release_after got %b exp 100110", st); end
    do_reset();
    m0_req = 1; m0_lock = 1;
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (st !== 6'b00_10_00) begin n_fail++; $display("FAIL release_idle got %b exp 001000", st); end
    tick();
    m0_req = 1; m1_req = 1;
    @(negedge clk);
    n_checks++;
    if (st !== 6'b01_00_10) begin n_fail++; $display("FAIL release_rr got %b exp 010010", st); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_req = 1; m0_lock = 1;
    tick();
    idle(); rst = 1;
    tick();
    rst = 0; m0_req = 1; m1_req = 1;
    @(negedge clk);
    n_checks++;
    if (st !== 6'b10_00_10) begin n_fail++; $display("FAIL reset_mid got %b exp 100010", st); end
    tick();
    idle(); m0_req = 1; rst = 1;
    tick();
    rst = 0; idle();
    @(negedge clk);
    n_checks++;
    if (st !== 6'b00_00_00) begin n_fail++; $display("FAIL reset_same_cycle got %b exp 000000", st); end
  endtask

  task automatic test_random();
    bit p0 = 0, p1 = 0;
    int g, w0 = 0, w1 = 0;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (!p0 && $urandom_range(0, 99) < 60) begin
        p0 = 1; m0_we = 1'($urandom_range(0, 1)); m0_lock = 1'($urandom_range(0, 1));
        m0_addr = AW'(512 + $urandom_range(0, 15)); m0_wdata = $urandom;
      end
      if (!p1 && $urandom_range(0, 99) < 80) begin
        p1 = 1; m1_we = 1'($urandom_range(0, 1)); m1_lock = 1'($urandom_range(0, 1));
        m1_addr = AW'(512 + $urandom_range(0, 15)); m1_wdata = $urandom;
      end
      m0_req = p0; m1_req = p1;
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      g = model_gnt();
      ea = (g == 0) ? m0_addr : (g == 1) ? m1_addr : '0;
      ed = (g == 0) ? m0_wdata : (g == 1) ? m1_wdata : '0;
      n_checks++;
      if ({m0_gnt, m1_gnt} !== {g == 0, g == 1}) begin
        n_fail++; $display("FAIL rand_gnt cyc %0d got %b%b exp %b%b", i, m0_gnt, m1_gnt, g == 0, g == 1);
      end
      n_checks++;
      if (mem_sel !== (g >= 0) || mem_we !== ((g == 0 && m0_we) || (g == 1 && m1_we)) || mem_addr !== ea || mem_wdata !== ed) begin
        n_fail++; $display("FAIL rand_mem cyc %0d got sel %b we %b addr %h wd %h exp addr %h wd %h", i, mem_sel, mem_we, mem_addr, mem_wdata, ea, ed);
      end
      n_checks++;
      if (m0_rvalid !== m_pend0 || m1_rvalid !== m_pend1) begin
        n_fail++; $display("FAIL rand_rvalid cyc %0d got %b%b exp %b%b", i, m0_rvalid, m1_rvalid, m_pend0, m_pend1);
      end
      if (m_pend0 || m_pend1) begin
        n_checks++;
        if (rdata !== m_rd) begin n_fail++; $display("FAIL rand_rdata cyc %0d got %h exp %h", i, rdata, m_rd); end
      end
      w0 = (!rst && m0_req && !m0_gnt) ? w0 + 1 : 0;
      w1 = (!rst && m1_req && !m1_gnt) ? w1 + 1 : 0;
      n_checks++;
      if (w0 > MB + 1 || w1 > MB + 1) begin n_fail++; $display("FAIL rand_starve cyc %0d got wait %0d/%0d exp <= %0d", i, w0, w1, MB + 1); end
      model_tick(g);
      if (g == 0) p0 = 0;
      if (g == 1) p1 = 0;
      tick();
    end
    rst = 0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_conflict();
    test_write_read();
    test_lock_burst();
    test_alternate();
    test_lock_release();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/xmem_arb.md
Name: xmem_arb

Overview:
- Two-requester arbiter sharing the single-port data memory between the accumulator processor's data bus (m0) and a DMA/host loader port (m1).
- Arbitration is round-robin with an optional lock for bursts. A burst-length limit guarantees fairness.
- The arbiter drives the memory strobes combinationally from the granted requester.
- It returns read data one cycle after a granted read, tagged to the owning requester.

Parameters:
- ADDR_W, 10, data memory address width
- DATA_W, 32, data word width
- MAX_BURST, 4, maximum consecutive locked grants while the other requester waits (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m0_req  in  1  requester 0 access request
- m0_we  in  1  requester 0 write enable (0 = read)
- m0_lock  in  1  requester 0 wants to retain ownership after this access
- m0_addr  in  ADDR_W  requester 0 address
- m0_wdata  in  DATA_W  requester 0 write data
- m0_gnt  out  1  requester 0 access accepted this cycle
- m0_rvalid  out  1  read data valid for requester 0
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid  same as m0 for requester 1
- rdata  out  DATA_W  read data, shared by both requesters; qualified by mN_rvalid
- mem_sel  out  1  memory select
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a read is selected

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- State registers:
  - last_gnt (1 bit): requester most recently granted.
  - lock_owner: NONE, M0 or M1.
  - burst_cnt (0..MAX_BURST).
  - rd_pend0 and rd_pend1: read-return flags.
- Reset: last_gnt=1 (so m0 wins the first conflict), lock_owner=NONE, burst_cnt=0, rd_pend0=rd_pend1=0.
  - Consequently after reset: m0_rvalid=m1_rvalid=0.
  - Combinational outputs follow the request inputs in the same cycle.
- Grant decision (combinational, at most one gnt high per cycle), in priority order:
  1. lock_owner=Mk, mk_req=1, and (burst_cnt<MAX_BURST or other req=0) -> grant Mk.
  2. lock_owner=Mk, mk_req=1, burst_cnt==MAX_BURST, other req=1 -> grant the other requester (forced rotation).
  3. No applicable lock, exactly one req -> grant it.
  4. No applicable lock, both req -> grant the requester not equal to last_gnt.
  5. No req -> no grant.
- Memory mux: mem_sel = m0_gnt|m1_gnt. mem_we, mem_addr and mem_wdata come from the granted requester. When nothing is granted, mem_we=0 and address/wdata are 0.
- State update on a grant to Mk:
  - last_gnt=k.
  - If mk_lock=1: lock_owner=Mk, and burst_cnt = (lock_owner was Mk) ? burst_cnt+1 : 1, saturating at MAX_BURST.
  - If mk_lock=0: lock_owner=NONE, burst_cnt=0.
- Lock release:
  - If lock_owner=Mk and mk_req=0 in a cycle, then lock_owner=NONE and burst_cnt=0 at the next edge, even if the other requester is granted.
  - A grant in that same cycle then applies the grant update rule above.
- Read return:
  - rd_pendk <= mk_gnt & ~mk_we. mk_rvalid = rd_pendk.
  - rdata = mem_rdata, combinational pass-through.
  - Writes never produce rvalid.
  - Back-to-back reads give rvalid every cycle.
  - Alternating owners give rvalid alternating with a 1-cycle lag.
- Non-granted requester: must hold req, we, addr and wdata stable until gnt. The arbiter never drops a pending request.
- Reset mid-operation: an rvalid due in the cycle after reset is suppressed. The lock is cleared.
- Starvation bound: a requester holding req waits at most MAX_BURST+1 cycles.

Test Plan:
1. After reset, m0 and m1 read the same cycle at addr 5 and 6 -> cycle0: m0_gnt=1, mem_addr=5. Cycle1: m1_gnt=1, mem_addr=6, m0_rvalid=1. Cycle2: m1_rvalid=1.
2. m1 alone writes 0xDEADBEEF at addr 3 (m1_we=1) -> m1_gnt same cycle, mem_we=1, mem_wdata=0xDEADBEEF, no rvalid. A following m0 read of addr 3 gives rdata=0xDEADBEEF with m0_rvalid the next cycle.
3. m1 continuous locked reads (m1_lock=1) while m0 requests from cycle 1, MAX_BURST=4 -> m1 granted cycles 0-3, m0 granted cycle 4, m1 granted cycle 5.
4. Both requesting continuously with no lock -> grants alternate m0, m1, m0, m1. Each grant yields the matching rvalid exactly one cycle later.
5. m0 locked, then drops req while m1 requests -> m1 granted that same cycle. lock_owner=NONE and burst_cnt=0 afterwards (if m1_lock=0).
6. rst asserted in the cycle after an m0 read grant -> m0_rvalid=0 the next cycle. The next conflict is won by m0.
